vector_rf_2p: RTL and testbench

- Parametrised two-port vector register file: one read port, one write port, usable in the same cycle.
- Sub-element write masking; write-first bypass when read and write hit the same address; configurable read latency.
- Self-clearing initialisation sequencer that zeroes every entry after reset.
- Sits in the vector unit between the issue stage (read operands) and the writeback stage (results). Array is behavioural RTL (flip-flop/inferred memory), no technology macro.

---
 rtl/vector_rf_2p.sv | 177 +++++++++++++++++
 tb/tb_vector_rf_2p.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_rf_2p.sv
// Two-port vector register file: one read and one write port, granule write masks,
// write-first bypass, self-clearing after reset and a read latency of 1 or 2 cycles.
module vector_rf_2p #(
   parameter int NUM_ELEMS           = 8,
   parameter int ELEM_SIZE           = 16,
   parameter int ENABLES_PER_ELEMENT = 4,
   parameter int VRF_SIZE            = 32,
   parameter int READ_LATENCY        = 1
) (
   input  logic                                    clk,
   input  logic                                    reset,
   output logic                                    ready,
   input  logic                                    rd_en,
   input  logic [$clog2(VRF_SIZE)-1:0]             rd_addr,
   output logic [NUM_ELEMS*ELEM_SIZE-1:0]          rd_data,
   output logic                                    rd_valid,
   input  logic                                    wr_en,
   input  logic [$clog2(VRF_SIZE)-1:0]             wr_addr,
   input  logic [NUM_ELEMS*ENABLES_PER_ELEMENT-1:0] wr_mask,
   input  logic [NUM_ELEMS*ELEM_SIZE-1:0]          wr_data
);

   localparam int W   = NUM_ELEMS * ELEM_SIZE;
   localparam int MW  = NUM_ELEMS * ENABLES_PER_ELEMENT;
   localparam int SUB = ELEM_SIZE / ENABLES_PER_ELEMENT;
   localparam int AW  = $clog2(VRF_SIZE);

   localparam logic [AW:0]   LP_DEPTH = (AW+1)'(VRF_SIZE);
   localparam logic [AW-1:0] LP_LAST  = AW'(VRF_SIZE - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Mask bit k (counted from the MSB side) selects granule k counted from the data MSB.
   function automatic logic [W-1:0] f_merge(
      input logic [W-1:0]  old_v,
      input logic [W-1:0]  new_v,
      input logic [MW-1:0] mask
   );
      logic [W-1:0] res;
      res = old_v;
      for (int k = 0; k < MW; k++) begin
         if (mask[MW-1-k]) begin
            res[W-1-k*SUB -: SUB] = new_v[W-1-k*SUB -: SUB];
         end
      end
      return res;
   endfunction

   logic [W-1:0]  r_mem [VRF_SIZE];

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_clr_cnt;
   logic          w_clr_last;

   logic          w_clr_we;
   logic          w_wr_we;
   logic          w_rd_acc;

   logic          w_wr_in_rng;
   logic          w_rd_in_rng;
   logic [W-1:0]  w_wr_old;
   logic [W-1:0]  w_wr_merged;
   logic [W-1:0]  w_rd_raw;
   logic [W-1:0]  w_rd_snap;
   logic          w_bypass;

   logic          r_vld_p1;
   logic [W-1:0]  r_data_p1;

   assign w_clr_last  = (r_clr_cnt == LP_LAST);
   assign w_wr_in_rng = ({1'b0, wr_addr} < LP_DEPTH);
   assign w_rd_in_rng = ({1'b0, rd_addr} < LP_DEPTH);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
         ST_RUN:   w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_CLEAR;
      endcase
   end

   always_comb begin
      ready    = 1'b0;
      w_clr_we = 1'b0;
      w_wr_we  = 1'b0;
      w_rd_acc = 1'b0;
      case (r_state)
         ST_CLEAR: w_clr_we = 1'b1;
         ST_RUN: begin
            ready    = 1'b1;
            w_wr_we  = wr_en && w_wr_in_rng;
            w_rd_acc = rd_en;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clr_cnt <= '0;
      end else if (w_clr_we) begin
         r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
      end
   end

   assign w_wr_old    = w_wr_in_rng ? r_mem[wr_addr] : '0;
   assign w_wr_merged = f_merge(w_wr_old, wr_data, wr_mask);

   // Array contents are not reset; the clear sequence zeroes them after every reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
         end else if (w_wr_we) begin
            r_mem[wr_addr] <= w_wr_merged;
         end
      end
   end

   // Write-first: a same-cycle write to the read address is folded into the snapshot.
   assign w_rd_raw  = w_rd_in_rng ? r_mem[rd_addr] : '0;
   assign w_bypass  = w_wr_we && (wr_addr == rd_addr);
   assign w_rd_snap = w_bypass ? w_wr_merged : w_rd_raw;

   // ---- stage p1: read snapshot taken at the issue edge ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_p1  <= 1'b0;
         r_data_p1 <= '0;
      end else begin
         r_vld_p1 <= w_rd_acc;
         if (w_rd_acc) begin
            r_data_p1 <= w_rd_snap;
         end
      end
   end

   generate
      if (READ_LATENCY >= 2) begin : g_lat2
         logic         r_vld_p2;
         logic [W-1:0] r_data_p2;

         // ---- stage p2: optional output register ----
         always_ff @(posedge clk) begin
            if (reset) begin
               r_vld_p2  <= 1'b0;
               r_data_p2 <= '0;
            end else begin
               r_vld_p2 <= r_vld_p1;
               if (r_vld_p1) begin
                  r_data_p2 <= r_data_p1;
               end
            end
         end

         assign rd_valid = r_vld_p2;
         assign rd_data  = r_data_p2;
      end else begin : g_lat1
         assign rd_valid = r_vld_p1;
         assign rd_data  = r_data_p1;
      end
   endgenerate

endmodule

// File: tb/tb_vector_rf_2p.sv
// Bench for vector_rf_2p: two instances (32 entries/latency 1 and 20 entries/latency 2)
// share one stimulus stream; a reference model feeds per-instance expected-read queues.
module tb_vector_rf_2p;

   logic          clk;
   logic          reset;
   logic          rd_en;
   logic [4:0]    rd_addr;
   logic          wr_en;
   logic [4:0]    wr_addr;
   logic [31:0]   wr_mask;
   logic [127:0]  wr_data;

   logic          ready_a, rd_valid_a;
   logic [127:0]  rd_data_a;
   logic          ready_b, rd_valid_b;
   logic [127:0]  rd_data_b;

   int            n_chk;
   int            n_pass;

   logic [127:0]  m_a [32];
   logic [127:0]  m_b [32];
   logic [127:0]  q_a [$];
   logic [127:0]  q_b [$];
   logic [127:0]  e_a, e_b, last_a, last_b;

   vector_rf_2p #(.VRF_SIZE(32), .READ_LATENCY(1)) u_a (
      .clk(clk), .reset(reset), .ready(ready_a),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data)
   );

   vector_rf_2p #(.VRF_SIZE(20), .READ_LATENCY(2)) u_b (
      .clk(clk), .reset(reset), .ready(ready_b),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
   endtask

   // Element/granule walk straight from the data layout description.
   function automatic logic [127:0] mrg(input logic [127:0] o, input logic [127:0] d,
                                        input logic [31:0] m);
      logic [127:0] r;
      r = o;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 4; j++)
            if (m[31-(i*4+j)]) r[127-i*16-j*4 -: 4] = d[127-i*16-j*4 -: 4];
      return r;
   endfunction

   always @(negedge clk) begin
      if (rd_valid_a) begin
         chk("valid_a_expected", 128'(q_a.size() != 0), 128'd1);
         if (q_a.size() != 0) begin
            e_a = q_a.pop_front();
            last_a = e_a;
            chk("rd_data_a", rd_data_a, e_a);
         end
      end
      if (rd_valid_b) begin
         chk("valid_b_expected", 128'(q_b.size() != 0), 128'd1);
         if (q_b.size() != 0) begin
            e_b = q_b.pop_front();
            last_b = e_b;
            chk("rd_data_b", rd_data_b, e_b);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
   endtask

   task automatic zero_models();
      for (int i = 0; i < 32; i++) begin
         m_a[i] = '0;
         m_b[i] = '0;
      end
   endtask

   // One RUN-mode cycle: drive, predict, advance one edge.
   task automatic issue(input logic re, input logic [4:0] ra, input logic we,
                        input logic [4:0] wa, input logic [31:0] wm, input logic [127:0] wd);
      logic [127:0] ea, eb;
      rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_mask = wm; wr_data = wd;
      if (re) begin
         ea = m_a[ra];
         if (we && wa == ra) ea = mrg(ea, wd, wm);
         q_a.push_back(ea);
         eb = (ra < 20) ? m_b[ra] : '0;
         if (we && wa == ra && ra < 20) eb = mrg(eb, wd, wm);
         q_b.push_back(eb);
      end
      if (we) begin
         m_a[wa] = mrg(m_a[wa], wd, wm);
         if (wa < 20) m_b[wa] = mrg(m_b[wa], wd, wm);
      end
      tick();
      idle_inputs();
   endtask

   task automatic drain(input string tag);
      repeat (4) tick();
      chk({tag, "_pending_a"}, 128'(q_a.size()), 128'd0);
      chk({tag, "_pending_b"}, 128'(q_b.size()), 128'd0);
   endtask

   // Called just after reset is released; requests made while clearing must be ignored.
   task automatic clear_check(input string tag);
      for (int s = 0; s <= 32; s++) begin
         if (s > 0) tick();
         chk({tag, "_ready_a"}, 128'(ready_a), 128'(s >= 32));
         chk({tag, "_ready_b"}, 128'(ready_b), 128'(s >= 20));
         if (s >= 1 && s <= 18) begin
            rd_en = 1'b1; rd_addr = 5'(s); wr_en = 1'b1; wr_addr = 5'(s - 1);
            wr_mask = '1; wr_data = '1;
         end else begin
            idle_inputs();
         end
      end
      idle_inputs();
   endtask

   task automatic read_all();
      for (int a = 0; a < 32; a++) issue(1'b1, 5'(a), 1'b0, '0, '0, '0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0]   ra, wa;
      logic [127:0] d25;
      n_chk = 0;
      n_pass = 0;
      last_a = '0;
      last_b = '0;
      zero_models();
      idle_inputs();

      reset = 1'b1;
      repeat (3) tick();
      chk("rst_ready_a", 128'(ready_a), 128'd0);
      chk("rst_ready_b", 128'(ready_b), 128'd0);
      chk("rst_valid_a", 128'(rd_valid_a), 128'd0);
      chk("rst_valid_b", 128'(rd_valid_b), 128'd0);
      chk("rst_data_a", rd_data_a, 128'd0);
      chk("rst_data_b", rd_data_b, 128'd0);

      reset = 1'b0;
      clear_check("clr1");
      read_all();
      drain("readall1");

      issue(1'b0, '0, 1'b1, 5'd5, '1, 128'h0123456789ABCDEF0123456789ABCDEF);
      issue(1'b1, 5'd5, 1'b0, '0, '0, '0);
      drain("wr5");

      issue(1'b0, '0, 1'b1, 5'd5, 32'h8000_0000, '1);
      issue(1'b1, 5'd5, 1'b0, '0, '0, '0);
      drain("mask5");
      chk("mask5_lit_a", rd_data_a, 128'hF123456789ABCDEF0123456789ABCDEF);
      chk("mask5_lit_b", rd_data_b, 128'hF123456789ABCDEF0123456789ABCDEF);

      issue(1'b1, 5'd7, 1'b1, 5'd7, 32'h0F00_0000, '1);
      issue(1'b0, '0, 1'b1, 5'd7, '1, {8{16'hAAAA}});
      drain("bypass7");
      chk("bypass7_lit_a", rd_data_a, 128'h0000FFFF000000000000000000000000);
      chk("bypass7_lit_b", rd_data_b, 128'h0000FFFF000000000000000000000000);

      d25 = 128'hDEADBEEF_00112233_44556677_8899AABB;
      issue(1'b0, '0, 1'b1, 5'd25, '1, d25);
      issue(1'b1, 5'd25, 1'b0, '0, '0, '0);
      drain("oor25");
      chk("oor25_lit_a", rd_data_a, d25);
      chk("oor25_lit_b", rd_data_b, 128'd0);

      for (int n = 0; n < 48; n++) begin
         ra = (n % 4 == 3) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 7));
         wa = (n % 5 == 4) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 7));
         issue(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
               32'($urandom), {$urandom, $urandom, $urandom, $urandom});
      end
      drain("random");
      repeat (3) tick();
      chk("hold_a", rd_data_a, last_a);
      chk("hold_b", rd_data_b, last_b);

      issue(1'b1, 5'd5, 1'b0, '0, '0, '0);
      reset = 1'b1;
      tick();
      q_a.delete();
      q_b.delete();
      zero_models();
      chk("rst2_ready_a", 128'(ready_a), 128'd0);
      chk("rst2_valid_b", 128'(rd_valid_b), 128'd0);
      chk("rst2_data_a", rd_data_a, 128'd0);
      chk("rst2_data_b", rd_data_b, 128'd0);
      tick();
      reset = 1'b0;
      repeat (10) tick();
      chk("midclr_ready_a", 128'(ready_a), 128'd0);
      chk("midclr_ready_b", 128'(ready_b), 128'd0);
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      clear_check("clr2");
      read_all();
      drain("readall2");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
